// File: rtl/peach_lsu.sv
// peach_lsu: load/store unit for the peach32 multi-cycle RV32I core.
// Forms the word address, byte enables and lane-shifted store data for one
// request. It runs a req/ack handshake with data memory and returns the
// extended load data with a one-cycle done pulse. Faulting requests never
// reach memory.
module peach_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] base_i,
    input  logic [31:0] offset_i,
    input  logic [31:0] store_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] load_data_o,
    output logic [1:0]  fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    typedef enum logic [1:0] {IDLE, CHECK, REQ, DONE} state_t;

    localparam logic [1:0] F_OK    = 2'd0;
    localparam logic [1:0] F_ALIGN = 2'd1;
    localparam logic [1:0] F_ILL   = 2'd2;
    localparam logic [1:0] F_TMO   = 2'd3;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [31:0] ea_q;
    logic [31:0] sd_q;
    logic [15:0] cnt_q;
    logic        busy_q, done_q, mem_req_q, mem_we_q;
    logic [1:0]  fault_q;
    logic [31:0] load_data_q, mem_addr_q, mem_wdata_q;
    logic [3:0]  mem_be_q;

    logic        illegal_d, misaligned_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, lane_d, ext_d;

    // Decode the latched request: legality, alignment, lanes and store data.
    always_comb begin
        illegal_d = is_store_q ? (funct3_q >= 3'd3)
                               : (funct3_q == 3'd3 || funct3_q == 3'd6 || funct3_q == 3'd7);
        misaligned_d = (funct3_q[1:0] == 2'd1 && ea_q[0]) ||
                       (funct3_q[1:0] == 2'd2 && ea_q[1:0] != 2'd0);
        be_d    = 4'b1111;
        wdata_d = sd_q;
        case (funct3_q[1:0])
            2'd0: begin
                be_d    = 4'b0001 << ea_q[1:0];
                wdata_d = {4{sd_q[7:0]}};
            end
            2'd1: begin
                be_d    = ea_q[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{sd_q[15:0]}};
            end
            default: ;
        endcase
    end

    // Pull the addressed lane down to bit 0 and extend it by access type.
    always_comb begin
        lane_d = mem_rdata_i >> {ea_q[1:0], 3'b000};
        case (funct3_q)
            3'd0:    ext_d = {{24{lane_d[7]}}, lane_d[7:0]};
            3'd1:    ext_d = {{16{lane_d[15]}}, lane_d[15:0]};
            3'd2:    ext_d = mem_rdata_i;
            3'd4:    ext_d = {24'd0, lane_d[7:0]};
            3'd5:    ext_d = {16'd0, lane_d[15:0]};
            default: ext_d = 32'd0;
        endcase
    end

    // Control FSM. All outputs are registered and change together with the state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'd0;
            ea_q        <= 32'd0;
            sd_q        <= 32'd0;
            cnt_q       <= 16'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= F_OK;
            load_data_q <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        is_store_q <= is_store_i;
                        funct3_q   <= funct3_i;
                        ea_q       <= base_i + offset_i;
                        sd_q       <= store_data_i;
                        busy_q     <= 1'b1;
                        state_q    <= CHECK;
                    end
                end
                CHECK: begin
                    // Illegal takes priority over misaligned.
                    if (illegal_d || misaligned_d) begin
                        fault_q     <= illegal_d ? F_ILL : F_ALIGN;
                        load_data_q <= 32'd0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= is_store_q;
                        mem_addr_q  <= {ea_q[31:2], 2'b00};
                        mem_be_q    <= be_d;
                        mem_wdata_q <= is_store_q ? wdata_d : 32'd0;
                        cnt_q       <= 16'd0;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    // An ack always wins, even in the cycle the timeout would fire.
                    if (mem_ack_i || cnt_q == TMO_LAST) begin
                        fault_q     <= mem_ack_i ? F_OK : F_TMO;
                        load_data_q <= (mem_ack_i && !is_store_q) ? ext_d : 32'd0;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= 32'd0;
                        mem_be_q    <= 4'd0;
                        mem_wdata_q <= 32'd0;
                        cnt_q       <= 16'd0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign fault_o     = fault_q;
    assign load_data_o = load_data_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_be_o    = mem_be_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
